// File: rtl/mem_port_arb.sv
// Fixed-priority arbiter sharing one multi-cycle memory between fetch (read) and data (read/write).
// Optional access watchdog with sticky err: define ARB_TIMEOUT_EN.
module mem_port_arb #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        i_stall,
    output logic        d_stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_e;

    localparam bit PARAM_OK = ((2 ** CNT_W) > TIMEOUT);
    if (!PARAM_OK) begin : g_bad_params
        $error("mem_port_arb: CNT_W too narrow for TIMEOUT");
    end

    state_e      state_q, state_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        arbitrate, mask_d, mask_i;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d, timeout_hit;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (state_q != IDLE) && !mem_done && (cnt_inc == CNT_W'(TIMEOUT));
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arbitrate   = 1'b0;
        mask_d      = 1'b0;
        mask_i      = 1'b0;

        // The port just served is masked for one cycle so the other side gets a turn.
        unique case (state_q)
            IDLE:    arbitrate = 1'b1;
            D_ACC:   if (mem_done) begin arbitrate = 1'b1; mask_d = 1'b1; end
            I_ACC:   if (mem_done) begin arbitrate = 1'b1; mask_i = 1'b1; end
            default: arbitrate = 1'b1;
        endcase

`ifdef ARB_TIMEOUT_EN
        if (timeout_hit) begin
            state_d     = IDLE;
            mem_en_d    = 1'b0;
            mem_wr_d    = 1'b0;
            mem_addr_d  = 16'h0000;
            mem_wdata_d = 16'h0000;
        end
`endif

        if (arbitrate) begin
            if (d_req && !mask_d) begin
                state_d     = D_ACC;
                mem_en_d    = 1'b1;
                mem_wr_d    = d_wr;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
            end else if (i_req && !mask_i) begin
                state_d     = I_ACC;
                mem_en_d    = 1'b1;
                mem_wr_d    = 1'b0;
                mem_addr_d  = i_addr;
                mem_wdata_d = 16'h0000;
            end else begin
                state_d     = IDLE;
                mem_en_d    = 1'b0;
                mem_wr_d    = 1'b0;
                mem_addr_d  = 16'h0000;
                mem_wdata_d = 16'h0000;
            end
        end

`ifdef ARB_TIMEOUT_EN
        err_d = err_q | timeout_hit;
        if (arbitrate && (state_d != IDLE)) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // An access abandoned by reset must not report completion in the reset cycle.
    assign i_done  = mem_done & (state_q == I_ACC) & ~rst;
    assign d_done  = mem_done & (state_q == D_ACC) & ~rst;
    assign i_rdata = i_done ? mem_rdata : 16'h0000;
    assign d_rdata = (d_done & ~mem_wr_q) ? mem_rdata : 16'h0000;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed plus random bench for mem_port_arb against a transaction-level reference model.
// Works for both builds; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_mem_port_arb;

    localparam int TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_wr, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err;
    logic [15:0] mem_addr, mem_wdata, i_rdata, d_rdata;

    always #5 clk = ~clk;

    mem_port_arb #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .i_rdata(i_rdata), .i_done(i_done), .d_rdata(d_rdata), .d_done(d_done),
        .i_stall(i_stall), .d_stall(d_stall), .err(err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the access currently owning the memory, if any.
    logic        m_valid = 1'b0;
    logic        m_fetch = 1'b0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_wdata = 16'h0000;
    logic        m_err = 1'b0;
    logic        m_fresh = 1'b1;
    int          m_wait = 0;
    logic        e_i_done, e_d_done;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model for the current cycle.
    task automatic cyc();
        #2;
        e_i_done = m_valid && m_fetch && mem_done && !rst;
        e_d_done = m_valid && !m_fetch && mem_done && !rst;
        chk("mem_en", {15'd0, mem_en}, {15'd0, m_valid});
        if (m_valid || m_fresh) begin
            chk("mem_wr", {15'd0, mem_wr}, {15'd0, m_wr});
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("i_done", {15'd0, i_done}, {15'd0, e_i_done});
        chk("d_done", {15'd0, d_done}, {15'd0, e_d_done});
        chk("i_rdata", i_rdata, e_i_done ? mem_rdata : 16'h0000);
        chk("d_rdata", d_rdata, (e_d_done && !m_wr) ? mem_rdata : 16'h0000);
        chk("i_stall", {15'd0, i_stall}, {15'd0, i_req && !e_i_done});
        chk("d_stall", {15'd0, d_stall}, {15'd0, d_req && !e_d_done});
        chk("err", {15'd0, err}, {15'd0, m_err});
    endtask

    // Advance the model by one clock using the arbitration rules, then cross the edge.
    task automatic adv();
        int  served;
        bit  may_grant;
        served    = 2;
        may_grant = 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_wr = 1'b0; m_addr = 16'h0000; m_wdata = 16'h0000;
            m_err = 1'b0; m_fresh = 1'b1; m_wait = 0;
        end else begin
            if (!m_valid) begin
                may_grant = 1'b1;
            end else if (mem_done) begin
                served    = m_fetch ? 1 : 0;
                m_valid   = 1'b0;
                may_grant = 1'b1;
            end else begin
                m_wait++;
                if (TO_ON && m_wait >= TIMEOUT) begin
                    m_valid = 1'b0;
                    m_err   = 1'b1;
                end
            end
            if (may_grant) begin
                if (d_req && served != 0) begin
                    m_valid = 1'b1; m_fetch = 1'b0; m_wr = d_wr; m_addr = d_addr;
                    m_wdata = d_wdata; m_wait = 0; m_fresh = 1'b0;
                end else if (i_req && served != 1) begin
                    m_valid = 1'b1; m_fetch = 1'b1; m_wr = 1'b0; m_addr = i_addr;
                    m_wdata = 16'h0000; m_wait = 0; m_fresh = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc();
        adv();
    endtask

    initial begin
        logic d_done_last, i_done_last;
        rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0; mem_done = 1'b0; mem_rdata = 16'h0;
        @(posedge clk);
        #1;
        step();

        // Data write, completes on the 3rd cycle after grant; late address change ignored.
        rst = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        step();
        d_addr = 16'h0777; d_wdata = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin mem_done = 1'b1; mem_rdata = 16'hAAAA; end
            cyc();
            chk("wr_mem_addr", mem_addr, 16'h0010);
            chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
            chk("wr_mem_wr", {15'd0, mem_wr}, 16'd1);
            chk("wr_d_done", {15'd0, d_done}, {15'd0, k == 2});
            chk("wr_d_rdata", d_rdata, 16'h0000);
            adv();
        end
        d_req = 1'b0; mem_done = 1'b0;
        cyc();
        chk("wr_idle_after", {15'd0, mem_en}, 16'd0);
        adv();

        // Simultaneous requests: data first, then fetch with no bubble.
        i_req = 1'b1; i_addr = 16'h0002; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        step();
        cyc();
        chk("pri_data_addr", mem_addr, 16'h0040);
        chk("pri_i_stall", {15'd0, i_stall}, 16'd1);
        adv();
        mem_done = 1'b1; mem_rdata = 16'h5555;
        cyc();
        chk("pri_d_rdata", d_rdata, 16'h5555);
        adv();
        d_req = 1'b0; mem_done = 1'b0;
        cyc();
        chk("pri_no_bubble_en", {15'd0, mem_en}, 16'd1);
        chk("pri_fetch_addr", mem_addr, 16'h0002);
        adv();
        mem_done = 1'b1; mem_rdata = 16'h1111;
        step();

        // Fetch held back-to-back gets one idle cycle, then reads 0x0004.
        i_addr = 16'h0004; mem_done = 1'b0;
        cyc();
        chk("fetch_b2b_idle", {15'd0, mem_en}, 16'd0);
        adv();
        cyc();
        chk("fetch_addr", mem_addr, 16'h0004);
        adv();
        mem_done = 1'b1; mem_rdata = 16'h1234;
        cyc();
        chk("fetch_rdata", i_rdata, 16'h1234);
        chk("fetch_i_done", {15'd0, i_done}, 16'd1);
        chk("fetch_d_rdata", d_rdata, 16'h0000);
        chk("fetch_d_done", {15'd0, d_done}, 16'd0);
        adv();
        i_req = 1'b0; mem_done = 1'b0;
        step();

        // Two consecutive data reads: exactly one idle cycle between them.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        cyc();
        chk("d_b2b_idle", {15'd0, mem_en}, 16'd0);
        adv();
        cyc();
        chk("d_b2b_regrant", {15'd0, mem_en}, 16'd1);
        adv();
        mem_done = 1'b1;
        step();
        d_req = 1'b0; mem_done = 1'b0;
        step();

        // Reset one cycle into a data access; later mem_done ignored.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h7777;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; d_req = 1'b0; mem_done = 1'b1;
        cyc();
        chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_no_done", {15'd0, d_done}, 16'd0);
        adv();
        mem_done = 1'b0;
        step();

        // Memory never answers.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT; k++) step();
        cyc();
        chk("to_err", {15'd0, err}, 16'd1);
        chk("to_mem_en", {15'd0, mem_en}, 16'd0);
        chk("to_d_stall", {15'd0, d_stall}, 16'd1);
        adv();
`else
        for (int k = 0; k < 110; k++) begin
            cyc();
            chk("hold_mem_en", {15'd0, mem_en}, 16'd1);
            adv();
        end
`endif
        rst = 1'b1;
        step();
        rst = 1'b0; d_req = 1'b0;
        step();

        // Random traffic: requests stay up until their done pulse.
        d_done_last = 1'b0;
        i_done_last = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            mem_done  = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            if (!d_req || d_done_last) begin
                d_req = 1'($urandom_range(0, 1));
                d_wr  = 1'($urandom_range(0, 1));
            end
            if (!i_req || i_done_last) i_req = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            cyc();
            d_done_last = e_d_done;
            i_done_last = e_i_done;
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
